// File: rtl/logic_op_pkg.sv
// Shared types for the logic-op arbiter: opcode encoding and output FSM states.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOT_A = 3'd0,
    OP_NOT_B = 3'd1,
    OP_AND   = 3'd2,
    OP_OR    = 3'd3,
    OP_NOR   = 3'd4,
    OP_NAND  = 3'd5,
    OP_XOR   = 3'd6,
    OP_XNOR  = 3'd7
  } op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/logic_unit.sv
// Combinational WIDTH-bit gate datapath; one of eight bitwise functions per op.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op_e'(op))
      OP_NOT_A: y = ~a;
      OP_NOT_B: y = ~b;
      OP_AND:   y = a & b;
      OP_OR:    y = a | b;
      OP_NOR:   y = ~(a | b);
      OP_NAND:  y = ~(a & b);
      OP_XOR:   y = a ^ b;
      OP_XNOR:  y = ~(a ^ b);
      default:  y = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic_unit among NUM_REQ requesters, with a
// single registered, id-tagged response port.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*OP_W-1:0]  req_op,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic [OP_W-1:0]          rsp_op
);

  // Handshake: a beat moves on either port only at a rising edge where valid
  // and ready are both 1; valid never waits on ready, ready may depend on valid.

  logic [OP_W-1:0]  op_arr [NUM_REQ];
  logic [WIDTH-1:0] a_arr  [NUM_REQ];
  logic [WIDTH-1:0] b_arr  [NUM_REQ];

  logic [IDW-1:0]   ptr_q;
  logic [IDW-1:0]   ptr_d;
  logic [IDW:0]     ptr_inc;
  logic [IDW:0]     scan;
  logic [IDW-1:0]   grant_idx;
  logic             grant_found;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] unit_y;

  out_state_e state_q;
  out_state_e state_d;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[i*OP_W +: OP_W];
      a_arr[i]  = req_a[i*WIDTH +: WIDTH];
      b_arr[i]  = req_b[i*WIDTH +: WIDTH];
    end
  end

  // First valid requester at or after the pointer, wrapping to index 0.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NUM_REQ)) begin
        scan = scan - (IDW+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[scan[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan[IDW-1:0];
      end
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign accept    = !rsp_valid || rsp_ready;
  // rst_n gating keeps req_ready low for the whole reset window.
  assign xfer      = rst_n && grant_found && accept;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  assign ptr_inc = {1'b0, grant_idx} + (IDW+1)'(1);
  assign ptr_d   = (ptr_inc >= (IDW+1)'(NUM_REQ)) ? '0 : ptr_inc[IDW-1:0];

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_logic_unit (
    .op (op_arr[grant_idx]),
    .a  (a_arr[grant_idx]),
    .b  (b_arr[grant_idx]),
    .y  (unit_y)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (xfer) state_d = ST_FULL;
      ST_FULL:  if (rsp_ready && !xfer) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Result fields and pointer only move on a request transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_op   <= '0;
      ptr_q    <= '0;
    end else if (xfer) begin
      rsp_data <= unit_y;
      rsp_id   <= grant_idx;
      rsp_op   <= op_arr[grant_idx];
      ptr_q    <= ptr_d;
    end
  end

endmodule
